simon_engine: RTL and testbench

Parametrised, self-contained Simon Says game engine. It generates a pseudo-random colour sequence from a seeded LFSR and stores it internally. It replays the first N colours on the LEDs and checks the player's button presses one at a time, ending the round on the first mistake. It replaces the fixed 4-colour / 32-bit-sequence / batch-check datapath and sits directly behind the tile pin wrapper.

---
 rtl/simon_pkg.sv | 25 ++
 rtl/simon_lfsr.sv | 30 +++
 rtl/simon_engine.sv | 158 +++++++++++++++
 tb/tb_simon_engine.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared state codes, LFSR constants and sizing helper for the Simon Says engine.
package simon_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_GEN      = 3'd1,
      ST_SHOW_ON  = 3'd2,
      ST_SHOW_OFF = 3'd3,
      ST_WAIT     = 3'd4,
      ST_WIN      = 3'd5,
      ST_LOSE     = 3'd6
   } state_t;

   // Fibonacci taps at bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;
   localparam logic [7:0] ZERO_SEED_SUB = 8'hA5;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR with seed load; colour is taken from the post-step value.
module simon_lfsr
   import simon_pkg::*;
#(
   parameter int OUT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [7:0]       seed,
   input  logic             step,
   output logic [OUT_W-1:0] colour
);

   logic [7:0] q;
   logic [7:0] q_next;

   assign q_next = {q[6:0], ^(q & LFSR_TAPS)};
   assign colour = q_next[OUT_W-1:0];

   always_ff @(posedge clk) begin
      if (rst)
         q <= ZERO_SEED_SUB;
      else if (load)
         q <= (seed == 8'h00) ? ZERO_SEED_SUB : seed;
      else if (step)
         q <= q_next;
   end

endmodule

// File: rtl/simon_engine.sv
// Simon Says engine: LFSR-generated sequence, timed LED replay, press-by-press checking.
// Optional WAIT input timeout is built only when SIMON_TIMEOUT_EN is defined.
module simon_engine
   import simon_pkg::*;
#(
   parameter int NUM_COLOURS    = 4,
   parameter int MAX_LEN        = 16,
   parameter int ON_CYCLES      = 4,
   parameter int OFF_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [7:0]                     seed,
   input  logic [NUM_COLOURS-1:0]         btn,
   output logic [NUM_COLOURS-1:0]         led,
   output logic [2:0]                     state,
   output logic [$clog2(MAX_LEN+1)-1:0]   round,
   output logic                           win,
   output logic                           lose
);

   localparam int CW = clog2(NUM_COLOURS);
   localparam int RW = $clog2(MAX_LEN + 1);
   localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int SHOW_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
`ifdef SIMON_TIMEOUT_EN
   localparam int TMAX = (TIMEOUT_CYCLES > SHOW_MAX) ? TIMEOUT_CYCLES : SHOW_MAX;
`else
   localparam int TMAX = SHOW_MAX;
`endif
   localparam int TW = clog2(TMAX + 1);

   if ((NUM_COLOURS != 2 && NUM_COLOURS != 4 && NUM_COLOURS != 8) ||
       MAX_LEN < 1 || MAX_LEN > 32 || ON_CYCLES < 1 || OFF_CYCLES < 1 ||
       TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("simon_engine: illegal parameter set");
   end

   state_t                 st;
   logic [RW-1:0]          idx;
   logic [TW-1:0]          tmr;
   logic [NUM_COLOURS-1:0] btn_prev;
   logic [CW-1:0]          mem [MAX_LEN];
   logic [CW-1:0]          new_colour;
   logic [NUM_COLOURS-1:0] exp_oh;
   logic                   press;
   logic                   last;
   logic                   idle_like;

   assign idle_like = (st == ST_IDLE) || (st == ST_WIN) || (st == ST_LOSE);
   assign press     = (|btn) && (btn_prev == '0);
   assign last      = (idx + RW'(1)) == round;

   simon_lfsr #(.OUT_W(CW)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load   (idle_like && start),
      .seed   (seed),
      .step   (st == ST_GEN),
      .colour (new_colour)
   );

   // Sequence memory is deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (!rst && st == ST_GEN)
         mem[round[AW-1:0]] <= new_colour;
   end

   always_comb begin
      exp_oh = '0;
      exp_oh[mem[idx[AW-1:0]]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= ST_IDLE;
         round    <= '0;
         idx      <= '0;
         tmr      <= '0;
         btn_prev <= '0;
      end else begin
         btn_prev <= btn;
         case (st)
            ST_IDLE, ST_WIN, ST_LOSE: begin
               if (start) begin
                  round <= '0;
                  idx   <= '0;
                  st    <= ST_GEN;
               end
            end
            ST_GEN: begin
               round <= round + RW'(1);
               idx   <= '0;
               tmr   <= '0;
               st    <= ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
               if (tmr == TW'(ON_CYCLES - 1)) begin
                  tmr <= '0;
                  st  <= ST_SHOW_OFF;
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            ST_SHOW_OFF: begin
               if (tmr == TW'(OFF_CYCLES - 1)) begin
                  tmr <= '0;
                  if (last) begin
                     idx <= '0;
                     st  <= ST_WAIT;
                  end else begin
                     idx <= idx + RW'(1);
                     st  <= ST_SHOW_ON;
                  end
               end else begin
                  tmr <= tmr + TW'(1);
               end
            end
            ST_WAIT: begin
               // exp_oh is always one-hot, so inequality also rejects multi-button chords
               if (press) begin
                  if (btn != exp_oh)
                     st <= ST_LOSE;
                  else if (last)
                     st <= (round == RW'(MAX_LEN)) ? ST_WIN : ST_GEN;
                  else begin
                     idx <= idx + RW'(1);
                     tmr <= '0;
                  end
               end
`ifdef SIMON_TIMEOUT_EN
               else if (tmr == TW'(TIMEOUT_CYCLES - 1))
                  st <= ST_LOSE;
               else
                  tmr <= tmr + TW'(1);
`endif
            end
            default: st <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      led = '0;
      case (st)
         ST_SHOW_ON: led = exp_oh;
         ST_WAIT:    led = btn;
         default:    led = '0;
      endcase
   end

   assign state = st;
   assign win   = (st == ST_WIN);
   assign lose  = (st == ST_LOSE);

endmodule

// File: tb/tb_simon_engine.sv
// Scoreboard bench for simon_engine: game-level script pushes per-cycle expected outputs,
// a negedge monitor pops and compares them.
module tb_simon_engine;

   localparam int NC  = 4;
   localparam int ML  = 4;
   localparam int ONC = 4;
   localparam int OFC = 2;
   localparam int TO  = 100;
   localparam int RW  = $clog2(ML + 1);

   // state codes as documented for the block
   localparam int C_IDLE = 0, C_GEN = 1, C_ON = 2, C_OFF = 3, C_WAIT = 4, C_WIN = 5, C_LOSE = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [7:0]    seed = 8'h00;
   logic [NC-1:0] btn = '0;
   logic [NC-1:0] led;
   logic [2:0]    state;
   logic [RW-1:0] round;
   logic          win, lose;

   simon_engine #(
      .NUM_COLOURS(NC), .MAX_LEN(ML), .ON_CYCLES(ONC), .OFF_CYCLES(OFC), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .btn(btn),
      .led(led), .state(state), .round(round), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]    st;
      logic [NC-1:0] led;
      logic [RW-1:0] rnd;
      logic          win;
      logic          lose;
   } obs_t;

   obs_t expq[$];
   int   checks = 0;
   int   errors = 0;

   // game-level reference state
   int            m_st, m_round, m_idx;
   logic [7:0]    m_lfsr;
   int            m_seq[$];
   logic [NC-1:0] hold_b, prev_btn;

   obs_t mon_e, mon_a;
   always @(negedge clk) begin
      if (expq.size() != 0) begin
         mon_e = expq.pop_front();
         mon_a.st = state; mon_a.led = led; mon_a.rnd = round; mon_a.win = win; mon_a.lose = lose;
         checks++;
         if (mon_a !== mon_e) begin
            errors++;
            $display("FAIL outputs t=%0t: got state=%0d led=%b round=%0d win=%b lose=%b, need state=%0d led=%b round=%0d win=%b lose=%b",
                     $time, mon_a.st, mon_a.led, mon_a.rnd, mon_a.win, mon_a.lose,
                     mon_e.st, mon_e.led, mon_e.rnd, mon_e.win, mon_e.lose);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] lfsr_next(input logic [7:0] q);
      logic fb;
      fb = q[7] ^ q[5] ^ q[4] ^ q[3];
      return {q[6:0], fb};
   endfunction

   function automatic logic [NC-1:0] oh(input int c);
      logic [NC-1:0] v;
      v = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   // drive one cycle and record what the outputs must show during it
   task automatic cyc(input logic s, input logic [NC-1:0] b, input int est, input logic [NC-1:0] eled);
      obs_t e;
      start = s;
      btn   = b;
      e.st = 3'(est); e.led = eled; e.rnd = RW'(m_round);
      e.win = (est == C_WIN); e.lose = (est == C_LOSE);
      expq.push_back(e);
      prev_btn = b;
      @(posedge clk); #1;
   endtask

   task automatic static_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         if (m_st == C_WAIT) cyc(1'($urandom_range(0, 1)), hold_b, m_st, hold_b);
         else                cyc(1'b0, hold_b, m_st, '0);
      end
   endtask

   task automatic gen_show();
      m_lfsr = lfsr_next(m_lfsr);
      m_seq.push_back(int'(m_lfsr[1:0]));
      cyc(1'($urandom_range(0, 1)), hold_b, C_GEN, '0);
      m_round++;
      foreach (m_seq[i]) begin
         repeat (ONC) cyc(1'($urandom_range(0, 1)), hold_b, C_ON, oh(m_seq[i]));
         repeat (OFC) cyc(1'($urandom_range(0, 1)), hold_b, C_OFF, '0);
      end
      m_st  = C_WAIT;
      m_idx = 0;
   endtask

   task automatic start_game(input logic [7:0] s);
      seed = s;
      cyc(1'b1, hold_b, m_st, '0);
      m_lfsr  = (s == 8'h00) ? 8'hA5 : s;
      m_round = 0;
      m_seq.delete();
      m_st = C_GEN;
      gen_show();
   endtask

   task automatic press(input logic [NC-1:0] b);
      logic evt;
      evt = (b != '0) && (prev_btn == '0);
      cyc(1'b0, b, C_WAIT, b);
      if (evt) begin
         if (b != oh(m_seq[m_idx]))   m_st = C_LOSE;
         else if (m_idx == m_round - 1) m_st = (m_round == ML) ? C_WIN : C_GEN;
         else                           m_idx++;
      end
      if (m_st == C_GEN) gen_show();
   endtask

   task automatic play_round();
      int r;
      r = m_round;
      hold_b = '0;
      while (m_st == C_WAIT && m_round == r) begin
         static_cycles(1 + $urandom_range(0, 3));
         press(oh(m_seq[m_idx]));
      end
   endtask

   initial begin
      int target, n_ok, c;
      logic [NC-1:0] wrong;
      hold_b = '0; prev_btn = '0; m_st = C_IDLE; m_round = 0; m_idx = 0; m_lfsr = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      cyc(1'b0, '0, C_IDLE, '0);
      rst = 1'b0;
      static_cycles(2);

      // seed 1: first colour 2, then hold the winning press across the round boundary
      start_game(8'h01);
      static_cycles(2);
      hold_b = 4'b0100;
      press(4'b0100);
      static_cycles(3);
      hold_b = '0;
      static_cycles(1);
      press(4'b0100);
      static_cycles(1);
      press(4'b0011);
      static_cycles(3);

      // same seed again, played to a win
      start_game(8'h01);
      while (m_st == C_WAIT) play_round();
      static_cycles(3);

      // random games ending in a wrong press or a win
      for (int g = 0; g < 8; g++) begin
         start_game((g == 3) ? 8'h00 : 8'($urandom));
         target = $urandom_range(1, ML + 1);
         while (m_st == C_WAIT && m_round < target) play_round();
         if (m_st == C_WAIT) begin
            n_ok = $urandom_range(0, m_round - 1);
            repeat (n_ok) begin
               static_cycles(1 + $urandom_range(0, 2));
               press(oh(m_seq[m_idx]));
            end
            c = m_seq[m_idx];
            wrong = ($urandom_range(0, 1) == 0) ? oh((c + 1 + $urandom_range(0, 2)) % NC)
                                                : (oh(c) | oh((c + 1) % NC));
            static_cycles(1);
            press(wrong);
         end
         static_cycles(2);
      end

      // reset in the middle of a replay
      seed = 8'($urandom);
      cyc(1'b1, '0, m_st, '0);
      m_lfsr = (seed == 8'h00) ? 8'hA5 : seed;
      m_lfsr = lfsr_next(m_lfsr);
      m_round = 0;
      cyc(1'b0, '0, C_GEN, '0);
      m_round = 1;
      repeat (2) cyc(1'b0, '0, C_ON, oh(int'(m_lfsr[1:0])));
      rst = 1'b1;
      cyc(1'b0, '0, C_ON, oh(int'(m_lfsr[1:0])));
      rst = 1'b0;
      m_st = C_IDLE; m_round = 0; m_seq.delete();
      static_cycles(2);

`ifdef SIMON_TIMEOUT_EN
      start_game(8'h01);
      static_cycles(TO);
      m_st = C_LOSE;
      static_cycles(2);
      start_game(8'h01);
      play_round();
      static_cycles(TO - 1);
      press(oh(m_seq[m_idx]));
      static_cycles(TO);
      m_st = C_LOSE;
      static_cycles(2);
`endif

      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, need 0", expq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
